// File: rtl/add_rs_bank.sv
// Adder-side reservation-station bank: three add/logic stations sharing one ALU,
// snooping the CDB for pending operands and broadcasting results under the station tag.
module add_rs_bank #(
  parameter int unsigned TAG_ADD_BASE = 1,
  parameter int unsigned TAG_MUL_BASE = 4,
  parameter int unsigned TAG_LS_BASE  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  rs_idx,
  input  logic [3:0]  operation,
  input  logic [3:0]  Qj,
  input  logic [3:0]  Qk,
  input  logic [31:0] Vj,
  input  logic [31:0] Vk,
  input  logic        MULT1_valid,
  input  logic        MULT2_valid,
  input  logic        LS_valid,
  input  logic [31:0] MULT1_result,
  input  logic [31:0] MULT2_result,
  input  logic [31:0] LS_value,
  input  logic [2:0]  LS_idx,
  output logic        busy_add1,
  output logic        busy_add2,
  output logic        busy_add3,
  output logic        ADD1_valid,
  output logic        ADD2_valid,
  output logic        ADD3_valid,
  output logic [31:0] ADD1_result,
  output logic [31:0] ADD2_result,
  output logic [31:0] ADD3_result,
  output logic        dispatch_drop
);

  localparam int unsigned NumRs  = 3;
  localparam int unsigned NumSrc = 4;

  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSlt  = 4'd5;
  localparam logic [3:0] OpSltu = 4'd6;

  typedef struct packed {
    logic        busy;
    logic        issued;
    logic [3:0]  op;
    logic [3:0]  qj;
    logic [3:0]  qk;
    logic [31:0] vj;
    logic [31:0] vk;
  } rs_t;

  rs_t         rs_q [NumRs];
  rs_t         rs_d [NumRs];
  logic        ex_valid_q, ex_valid_d;
  logic [1:0]  ex_idx_q, ex_idx_d;
  logic [31:0] ex_result_q, ex_result_d;
  logic        drop;

  logic [NumSrc-1:0]       cdb_vld;
  logic [NumSrc-1:0][3:0]  cdb_tag;
  logic [NumSrc-1:0][31:0] cdb_val;

  function automatic logic [3:0] add_tag(input logic [1:0] idx);
    return 4'(TAG_ADD_BASE) + {2'b00, idx};
  endfunction

  // Returns {hit, value}; tag 0 means "value already present" and never hits.
  function automatic logic [32:0] snoop(input logic [3:0]              tag,
                                        input logic [NumSrc-1:0]       vld,
                                        input logic [NumSrc-1:0][3:0]  tags,
                                        input logic [NumSrc-1:0][31:0] vals);
    logic [32:0] r;
    r = '0;
    for (int s = 0; s < NumSrc; s++) begin
      if (tag != 4'd0 && vld[s] && tags[s] == tag) r = {1'b1, vals[s]};
    end
    return r;
  endfunction

  function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [31:0] r;
    case (op)
      OpSub:   r = a - b;
      OpAnd:   r = a & b;
      OpOr:    r = a | b;
      OpXor:   r = a ^ b;
      OpSlt:   r = {31'b0, $signed(a) < $signed(b)};
      OpSltu:  r = {31'b0, a < b};
      default: r = a + b;
    endcase
    return r;
  endfunction

  // Own results come back through the execute register, like any other CDB source.
  always_comb begin
    cdb_vld    = {ex_valid_q, LS_valid, MULT2_valid, MULT1_valid};
    cdb_tag[0] = 4'(TAG_MUL_BASE);
    cdb_tag[1] = 4'(TAG_MUL_BASE + 1);
    cdb_tag[2] = 4'(TAG_LS_BASE) + {1'b0, LS_idx};
    cdb_tag[3] = add_tag(ex_idx_q);
    cdb_val[0] = MULT1_result;
    cdb_val[1] = MULT2_result;
    cdb_val[2] = LS_value;
    cdb_val[3] = ex_result_q;
  end

  always_comb begin
    logic        found;
    logic [32:0] fj;
    logic [32:0] fk;
    rs_d        = rs_q;
    ex_valid_d  = 1'b0;
    ex_idx_d    = 2'd0;
    ex_result_d = '0;
    drop        = 1'b0;
    found       = 1'b0;
    fj          = '0;
    fk          = '0;

    // Issue: lowest-index ready station wins.
    for (int i = 0; i < NumRs; i++) begin
      if (!found && rs_q[i].busy && !rs_q[i].issued &&
          rs_q[i].qj == 4'd0 && rs_q[i].qk == 4'd0) begin
        found          = 1'b1;
        ex_valid_d     = 1'b1;
        ex_idx_d       = 2'(i);
        ex_result_d    = alu(rs_q[i].op, rs_q[i].vj, rs_q[i].vk);
        rs_d[i].issued = 1'b1;
      end
    end

    for (int i = 0; i < NumRs; i++) begin
      if (rs_q[i].busy) begin
        fj = snoop(rs_q[i].qj, cdb_vld, cdb_tag, cdb_val);
        fk = snoop(rs_q[i].qk, cdb_vld, cdb_tag, cdb_val);
        if (fj[32]) begin
          rs_d[i].vj = fj[31:0];
          rs_d[i].qj = 4'd0;
        end
        if (fk[32]) begin
          rs_d[i].vk = fk[31:0];
          rs_d[i].qk = 4'd0;
        end
      end
      if (ex_valid_q && ex_idx_q == 2'(i)) rs_d[i].busy = 1'b0;
    end

    // Dispatch only touches idle stations, so it never collides with snoop or free.
    for (int i = 0; i < NumRs; i++) begin
      if (rs_idx == add_tag(2'(i))) begin
        if (rs_q[i].busy) begin
          drop = 1'b1;
        end else begin
          fj             = snoop(Qj, cdb_vld, cdb_tag, cdb_val);
          fk             = snoop(Qk, cdb_vld, cdb_tag, cdb_val);
          rs_d[i].busy   = 1'b1;
          rs_d[i].issued = 1'b0;
          rs_d[i].op     = operation;
          rs_d[i].qj     = fj[32] ? 4'd0 : Qj;
          rs_d[i].qk     = fk[32] ? 4'd0 : Qk;
          rs_d[i].vj     = fj[32] ? fj[31:0] : Vj;
          rs_d[i].vk     = fk[32] ? fk[31:0] : Vk;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRs; i++) rs_q[i] <= '0;
      ex_valid_q  <= 1'b0;
      ex_idx_q    <= 2'd0;
      ex_result_q <= '0;
    end else begin
      for (int i = 0; i < NumRs; i++) rs_q[i] <= rs_d[i];
      ex_valid_q  <= ex_valid_d;
      ex_idx_q    <= ex_idx_d;
      ex_result_q <= ex_result_d;
    end
  end

  assign busy_add1     = rs_q[0].busy;
  assign busy_add2     = rs_q[1].busy;
  assign busy_add3     = rs_q[2].busy;
  assign ADD1_valid    = ex_valid_q && ex_idx_q == 2'd0;
  assign ADD2_valid    = ex_valid_q && ex_idx_q == 2'd1;
  assign ADD3_valid    = ex_valid_q && ex_idx_q == 2'd2;
  assign ADD1_result   = ADD1_valid ? ex_result_q : '0;
  assign ADD2_result   = ADD2_valid ? ex_result_q : '0;
  assign ADD3_result   = ADD3_valid ? ex_result_q : '0;
  assign dispatch_drop = drop;

endmodule
